tdm_demux4: RTL

- Time-division demultiplexer: the receive end of a 4-channel TDM link whose transmit end is a 4:1 mux stepped through its select codes one slot per sample.
- Accepts one sample per valid cycle, tracks slot position from a frame marker, and reconstructs the four channel values.
- All four channels are presented in parallel, updated atomically once per complete frame.
- Sits between the serial TDM link and per-channel consumers.

---
 rtl/tdm_demux4_if.sv | 38 +++
 rtl/tdm_demux4.sv | 96 +++++++++
 2 files changed

// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-channel TDM receiver: serial sample side plus the
// reconstructed parallel frame and link status.
interface tdm_demux4_if #(
  parameter int WIDTH = 1
);

  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   frame_start;
  logic [4*WIDTH-1:0]     out_data;
  logic                   out_valid;
  logic [1:0]             slot;
  logic                   locked;
  logic                   sync_err;

  modport master (
    output in_valid,
    output in_data,
    output frame_start,
    input  out_data,
    input  out_valid,
    input  slot,
    input  locked,
    input  sync_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  frame_start,
    output out_data,
    output out_valid,
    output slot,
    output locked,
    output sync_err
  );

endinterface

// File: rtl/tdm_demux4.sv
// Receive end of a 4-slot TDM link: locks onto the frame marker, collects
// slots 0..2 in shadow registers and publishes all four channels at once.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  tdm_demux4_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         r_state;
  logic [1:0]         r_slot;
  logic [WIDTH-1:0]   r_ch0;
  logic [WIDTH-1:0]   r_ch1;
  logic [WIDTH-1:0]   r_ch2;
  logic [4*WIDTH-1:0] r_out_data;
  logic               r_out_valid;
  logic               r_sync_err;

  logic               w_accept;
  logic               w_marker;

  assign w_accept = bus.in_valid;
  assign w_marker = bus.in_valid & bus.frame_start;

  // A marker always restarts collection at slot 0; it only counts as an error
  // when it arrives before the current frame was complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_slot      <= 2'd0;
      r_ch0       <= '0;
      r_ch1       <= '0;
      r_ch2       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_sync_err  <= 1'b0;
      if (w_accept) begin
        case (r_state)
          ST_IDLE: begin
            if (w_marker) begin
              r_ch0   <= bus.in_data;
              r_slot  <= 2'd1;
              r_state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (w_marker) begin
              r_ch0      <= bus.in_data;
              r_slot     <= 2'd1;
              r_sync_err <= (r_slot != 2'd0);
            end else begin
              case (r_slot)
                2'd0: begin
                  r_sync_err <= 1'b1;
                  r_slot     <= 2'd0;
                  r_state    <= ST_IDLE;
                end
                2'd1: begin
                  r_ch1  <= bus.in_data;
                  r_slot <= 2'd2;
                end
                2'd2: begin
                  r_ch2  <= bus.in_data;
                  r_slot <= 2'd3;
                end
                default: begin
                  r_out_data  <= {bus.in_data, r_ch2, r_ch1, r_ch0};
                  r_out_valid <= 1'b1;
                  r_slot      <= 2'd0;
                end
              endcase
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_slot  <= 2'd0;
          end
        endcase
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.slot      = r_slot;
  assign bus.locked    = (r_state == ST_RUN);
  assign bus.sync_err  = r_sync_err;

endmodule
